oq_dequeue_scheduler: RTL and testbench

Round-robin scheduler that picks which output queue is dequeued next and sequences the remove path of the output-queue register file. It sits between the per-queue status flags (empty, enable, output-port ready) and the SRAM read engine. For each winning queue it issues a one-cycle `src_update` to the queue registers, then hands the queue number to the read engine. It holds off further grants until the read completes and the lagging status flags have settled.

---
 rtl/oq_dequeue_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_oq_dequeue_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/oq_dequeue_scheduler.sv
// Round-robin dequeue scheduler for the output-queue register file.
// It picks the next eligible queue, pulses src_update for that queue, then
// hands the queue number to the SRAM read engine. After the read finishes it
// waits for the lagging status flags to settle before it arbitrates again.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   empty, enable,      per-queue status, sampled only while idle
//   port_ready
//   initialize,         re-initialization strobe; masks that queue while idle
//   initialize_oq
//   src_update, src_oq  one-cycle remove-side update strobe and its queue
//   rd_req, rd_oq       request to the read engine and the queue to read
//   rd_ack, rd_done     read engine accepted / packet fully read
//   busy                high whenever the scheduler is not idle
//   timeout_err,        sticky watchdog flag and its clear
//   err_clear
module oq_dequeue_scheduler #(
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter int unsigned NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int unsigned SETTLE_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0] enable,
  input  logic [NUM_OUTPUT_QUEUES-1:0] port_ready,
  input  logic                         initialize,
  input  logic [NUM_OQ_WIDTH-1:0]      initialize_oq,
  output logic                         src_update,
  output logic [NUM_OQ_WIDTH-1:0]      src_oq,
  output logic                         rd_req,
  output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
  input  logic                         rd_ack,
  input  logic                         rd_done,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         err_clear
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The watchdog fires on the cycle its count would reach TIMEOUT_CYCLES.
  localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0]     SettleLast = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StUpdate, StReq, StBusy, StSettle} state_e;

  state_e                    state_q, state_d;
  logic [NUM_OQ_WIDTH-1:0]   last_q, last_d;
  logic                      src_update_q, src_update_d;
  logic [NUM_OQ_WIDTH-1:0]   src_oq_q, src_oq_d;
  logic                      rd_req_q, rd_req_d;
  logic [NUM_OQ_WIDTH-1:0]   rd_oq_q, rd_oq_d;
  logic [3:0]                settle_cnt_q, settle_cnt_d;
  logic [WdW-1:0]            wd_cnt_q, wd_cnt_d;
  logic                      timeout_err_q, timeout_err_d;

  logic [NUM_OUTPUT_QUEUES-1:0] elig;
  logic                         win_found;
  logic [NUM_OQ_WIDTH-1:0]      win_oq;
  logic [WdW-1:0]               wd_inc;
  logic                         wd_hit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      elig[i] = enable[i] & ~empty[i] & port_ready[i] &
                ~(initialize & (initialize_oq == NUM_OQ_WIDTH'(i)));
    end
  end

  // Search starts just after the last grant and checks last_q itself last.
  always_comb begin
    int unsigned idx;
    logic [NUM_OQ_WIDTH-1:0] sel;
    idx       = 0;
    sel       = '0;
    win_found = 1'b0;
    win_oq    = '0;
    for (int unsigned k = 1; k <= NUM_OUTPUT_QUEUES; k++) begin
      idx = (32'(last_q) + k) % NUM_OUTPUT_QUEUES;
      sel = NUM_OQ_WIDTH'(idx);
      if (!win_found && elig[sel]) begin
        win_found = 1'b1;
        win_oq    = sel;
      end
    end
  end

  assign wd_inc = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + 1'b1;
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WdLast);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    src_update_d  = src_update_q;
    src_oq_d      = src_oq_q;
    rd_req_d      = rd_req_q;
    rd_oq_d       = rd_oq_q;
    settle_cnt_d  = settle_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;

    // A timeout raised below overrides a simultaneous clear.
    if (err_clear) timeout_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          src_update_d = 1'b1;
          src_oq_d     = win_oq;
          last_d       = win_oq;
          state_d      = StUpdate;
        end
      end
      StUpdate: begin
        src_update_d = 1'b0;
        rd_req_d     = 1'b1;
        rd_oq_d      = src_oq_q;
        wd_cnt_d     = '0;
        state_d      = StReq;
      end
      StReq: begin
        wd_cnt_d = wd_inc;
        if (wd_hit) begin
          timeout_err_d = 1'b1;
          rd_req_d      = 1'b0;
          settle_cnt_d  = '0;
          state_d       = StSettle;
        end else if (rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        wd_cnt_d = wd_inc;
        if (wd_hit) begin
          timeout_err_d = 1'b1;
          settle_cnt_d  = '0;
          state_d       = StSettle;
        end else if (rd_done) begin
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          settle_cnt_d = '0;
          state_d      = StIdle;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_q        <= NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
      src_update_q  <= 1'b0;
      src_oq_q      <= '0;
      rd_req_q      <= 1'b0;
      rd_oq_q       <= '0;
      settle_cnt_q  <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      src_update_q  <= src_update_d;
      src_oq_q      <= src_oq_d;
      rd_req_q      <= rd_req_d;
      rd_oq_q       <= rd_oq_d;
      settle_cnt_q  <= settle_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign src_update  = src_update_q;
  assign src_oq      = src_oq_q;
  assign rd_req      = rd_req_q;
  assign rd_oq       = rd_oq_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_oq_dequeue_scheduler.sv
// Directed bench for oq_dequeue_scheduler (SETTLE_CYCLES=2, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_oq_dequeue_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] empty, enable, port_ready;
  logic       initialize;
  logic [2:0] initialize_oq;
  logic       src_update;
  logic [2:0] src_oq;
  logic       rd_req;
  logic [2:0] rd_oq;
  logic       rd_ack, rd_done;
  logic       busy;
  logic       timeout_err;
  logic       err_clear;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_grant_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oq_dequeue_scheduler #(
    .NUM_OUTPUT_QUEUES (8),
    .NUM_OQ_WIDTH      (3),
    .SETTLE_CYCLES     (2),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .empty         (empty),
    .enable        (enable),
    .port_ready    (port_ready),
    .initialize    (initialize),
    .initialize_oq (initialize_oq),
    .src_update    (src_update),
    .src_oq        (src_oq),
    .rd_req        (rd_req),
    .rd_oq         (rd_oq),
    .rd_ack        (rd_ack),
    .rd_done       (rd_done),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clear     (err_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Wait (bounded) for the src_update pulse and check the granted queue.
  task automatic wait_grant(input string tag, input logic [2:0] q, input bit chk_gap);
    int g;
    g = 0;
    while (!src_update && g < 30) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_upd"}, {31'd0, src_update}, 32'd1);
    check({tag, "_oq"}, {29'd0, src_oq}, {29'd0, q});
    if (chk_gap) check({tag, "_gap"}, cyc - last_grant_cyc, 32'd6);
    last_grant_cyc = cyc;
  endtask

  // Fast read engine: ack in the first rd_req cycle, done one cycle later.
  task automatic serve(input string tag, input logic [2:0] q, input logic [7:0] pr_busy);
    @(negedge clk);
    check({tag, "_req"}, {31'd0, rd_req}, 32'd1);
    check({tag, "_rdoq"}, {29'd0, rd_oq}, {29'd0, q});
    check({tag, "_pulse"}, {31'd0, src_update}, 32'd0);
    rd_ack = 1'b1;
    @(negedge clk);
    check({tag, "_reqw"}, {31'd0, rd_req}, 32'd0);
    rd_ack     = 1'b0;
    rd_done    = 1'b1;
    port_ready = pr_busy;
    @(negedge clk);
    rd_done = 1'b0;
    check({tag, "_settle"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; empty = 8'hFF; enable = 8'hFF; port_ready = 8'hFF;
    initialize = 1'b0; initialize_oq = 3'd0; rd_ack = 1'b0; rd_done = 1'b0;
    err_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_upd", {31'd0, src_update}, 32'd0);
    check("rst_req", {31'd0, rd_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, timeout_err}, 32'd0);
    check("rst_srcoq", {29'd0, src_oq}, 32'd0);

    // Queues 2 and 5 alternate.
    empty = ~8'h24;
    reset = 1'b0;
    wait_grant("t1g0", 3'd2, 1'b0); serve("t1s0", 3'd2, 8'hFF);
    wait_grant("t1g1", 3'd5, 1'b1); serve("t1s1", 3'd5, 8'hFF);
    wait_grant("t1g2", 3'd2, 1'b1); serve("t1s2", 3'd2, 8'hFF);
    wait_grant("t1g3", 3'd5, 1'b1); serve("t1s3", 3'd5, 8'hFF);

    // All queues eligible after a fresh reset: 0..7 then 0.
    reset = 1'b1;
    empty = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_grant($sformatf("t2g%0d", i), 3'(i % 8), i != 0);
      serve($sformatf("t2s%0d", i), 3'(i % 8), 8'hFF);
    end

    // Queue 3 only; port_ready[3] drops while the read is in flight.
    empty = ~8'h08;
    wait_grant("t3g0", 3'd3, 1'b0);
    serve("t3s0", 3'd3, 8'hF7);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (src_update) cnt++;
    end
    check("t3_noregrant", cnt, 32'd0);
    check("t3_idle", {31'd0, busy}, 32'd0);
    port_ready = 8'hFF;
    wait_grant("t3g1", 3'd3, 1'b0);
    serve("t3s1", 3'd3, 8'hFF);

    // initialize masks queue 4 for exactly the cycle it is asserted.
    empty = 8'hFF;
    repeat (4) @(negedge clk);
    empty = ~8'h10; initialize = 1'b1; initialize_oq = 3'd4;
    @(negedge clk);
    check("t4_masked", {31'd0, src_update}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    initialize = 1'b0;
    @(negedge clk);
    check("t4_upd", {31'd0, src_update}, 32'd1);
    check("t4_oq", {29'd0, src_oq}, 32'd4);
    serve("t4s", 3'd4, 8'hFF);

    // Watchdog: no rd_ack ever.
    empty = 8'hFF;
    repeat (4) @(negedge clk);
    empty = ~8'h02;
    wait_grant("t5g", 3'd1, 1'b0);
    @(negedge clk);
    empty = 8'hFF;
    cnt = 0;
    while (rd_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_reqlen", cnt, 32'd16);
    check("t5_err", {31'd0, timeout_err}, 32'd1);
    check("t5_busy0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t5_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_sticky", {31'd0, timeout_err}, 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("t5_clr", {31'd0, timeout_err}, 32'd0);

    // Reset during BUSY, then during REQ.
    empty = ~8'h41;
    wait_grant("t6g", 3'd6, 1'b0);
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rbusy", {31'd0, busy}, 32'd0);
    check("t6_rsrcoq", {29'd0, src_oq}, 32'd0);
    check("t6_rrdoq", {29'd0, rd_oq}, 32'd0);
    check("t6_rreq", {31'd0, rd_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_grant("t6g0", 3'd0, 1'b0);
    @(negedge clk);
    check("t6_req", {31'd0, rd_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_reqdrop", {31'd0, rd_req}, 32'd0);
    check("t6_upddrop", {31'd0, src_update}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
